// File: rtl/load_store_unit_if.sv
// Core-side request and data-memory bus bundle for the load/store unit.
// The unit uses the slave view; core and memory together drive the master view.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_write;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  busy;
    logic                  done;
    logic                  fault;
    logic [31:0]           load_data;
    logic                  mem_valid;
    logic                  mem_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [3:0]            mem_wstrb;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    modport slave (
        input  req_valid, req_write, req_funct3,
        input  req_addr, req_wdata,
        input  mem_ready, mem_rdata,
        output busy, done, fault, load_data,
        output mem_valid, mem_we, mem_addr,
        output mem_wstrb, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_funct3,
        output req_addr, req_wdata,
        output mem_ready, mem_rdata,
        input  busy, done, fault, load_data,
        input  mem_valid, mem_we, mem_addr,
        input  mem_wstrb, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: aligns one access onto a valid/ready
// word bus and returns sign/zero-extended load data.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input logic               clk,
    input logic               rst_n,
    load_store_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_e;

    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [2:0]            f3_q, f3_d;
    logic [1:0]            off_q, off_d;
    logic [31:0]           ld_q, ld_d;
    logic                  fault_q, fault_d;

    logic [1:0]  off;
    logic        illegal;
    logic        misaligned;
    logic [3:0]  strb;
    logic [31:0] wdata_rep;

    function automatic logic [31:0] fmt_load(
        input logic [2:0]  f3,
        input logic [1:0]  sh,
        input logic [31:0] rd
    );
        logic [31:0] s;
        s = rd >> {sh, 3'b000};
        case (f3)
            3'b000:  fmt_load = {{24{s[7]}}, s[7:0]};
            3'b001:  fmt_load = {{16{s[15]}}, s[15:0]};
            3'b100:  fmt_load = {24'h0, s[7:0]};
            3'b101:  fmt_load = {16'h0, s[15:0]};
            default: fmt_load = s;
        endcase
    endfunction

    assign off = bus.req_addr[1:0];

    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        strb       = 4'b1111;
        wdata_rep  = bus.req_wdata;
        if (bus.req_write) begin
            illegal = !(bus.req_funct3 inside
                        {3'b000, 3'b001, 3'b010});
        end else begin
            illegal = bus.req_funct3 inside
                      {3'b011, 3'b110, 3'b111};
        end
        // f3[1:0] encodes width for every legal code
        unique case (1'b1)
            bus.req_funct3[1:0] == 2'b00: begin
                strb      = 4'b0001 << off;
                wdata_rep = {4{bus.req_wdata[7:0]}};
            end
            bus.req_funct3[1:0] == 2'b01: begin
                misaligned = off[0];
                strb       = 4'b0011 << off;
                wdata_rep  = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                misaligned = (off != 2'b00);
            end
        endcase
        if (!bus.req_write) begin
            strb = 4'b0000;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        off_d   = off_q;
        ld_d    = ld_q;
        fault_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (illegal || misaligned) begin
                        state_d = DONE;
                        fault_d = 1'b1;
                    end else begin
                        state_d = REQ;
                        we_d    = bus.req_write;
                        addr_d  = {bus.req_addr[ADDR_WIDTH-1:2],
                                   2'b00};
                        wstrb_d = strb;
                        wdata_d = wdata_rep;
                        f3_d    = bus.req_funct3;
                        off_d   = off;
                    end
                end
            end
            REQ: begin
                if (bus.mem_ready) begin
                    state_d = DONE;
                    if (!we_q) begin
                        ld_d = fmt_load(f3_q, off_q,
                                        bus.mem_rdata);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wstrb_q <= 4'b0000;
            wdata_q <= 32'h0;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            ld_q    <= 32'h0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            ld_q    <= ld_d;
            fault_q <= fault_d;
        end
    end

    assign bus.mem_valid = (state_q == REQ);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wstrb = wstrb_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.done      = (state_q == DONE);
    assign bus.fault     = fault_q;
    assign bus.load_data = ld_q;
    assign bus.busy      = bus.req_valid & ~bus.done;
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle data-memory access unit for the non-pipelined core. Sits between the execute stage and the data memory. It takes a load or store request, performs byte-lane alignment, issues one transfer on a valid/ready memory bus, and returns sign- or zero-extended load data. That load data feeds the memory input of the writeback result select. It holds the core stalled until the access completes or faults.

## Interface
- ADDR_WIDTH, 32, byte-address width; data width is fixed at 32.

- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  access request; core holds it and all req_* stable until done.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-aligned.
- busy  out  1  combinational stall = req_valid & ~done.
- done  out  1  one-cycle completion pulse.
- fault  out  1  valid with done; access was misaligned or illegal.
- load_data  out  32  registered extended load result.
- mem_valid  out  1  bus request.
- mem_ready  in  1  bus accept/complete; ignored while mem_valid = 0.
- mem_we  out  1  bus write enable.
- mem_addr  out  ADDR_WIDTH  word-aligned address {req_addr[ADDR_WIDTH-1:2], 2'b00}.
- mem_wstrb  out  4  byte-lane write strobes; 0000 on loads.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  read data, sampled when mem_valid & mem_ready.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE with req_valid, legal and aligned:
  - latch address, we, strobes, wdata and funct3;
  - go to REQ.
- IDLE with req_valid, illegal or misaligned:
  - go to DONE with fault = 1;
  - no bus transfer.
- REQ:
  - mem_valid = 1, and all mem_* outputs are held constant;
  - on mem_ready, a load captures the formatted mem_rdata into load_data;
  - on mem_ready, go to DONE.
- DONE: done = 1 for exactly one cycle, then go to IDLE. req_valid is ignored in DONE.
- Illegal funct3 codes:
  - loads: 011, 110, 111;
  - stores: any code other than 000, 001, 010.
- Misaligned:
  - H or HU with addr[0] = 1;
  - W with addr[1:0] != 00.
- Store strobes:
  - SB: 0001 << addr[1:0];
  - SH: 0011 << addr[1:0];
  - SW: 1111.
- Store data: byte replicated ×4 for SB, halfword replicated ×2 for SH, word as-is for SW.
- Load extraction: shift mem_rdata right by 8*addr[1:0], then take 8 or 16 bits (or all 32 for W).
  - B and H: sign-extend bit 7 or bit 15.
  - BU and HU: zero-extend.
- load_data is updated only by successful loads. Stores and faults leave it unchanged, and it holds between accesses.
- fault is cleared in every cycle other than a faulting DONE.

## Timing
- Reset (async, rst_n = 0): state IDLE; mem_valid, mem_we, done and fault = 0; mem_wstrb = 0000; mem_addr, mem_wdata and load_data = 0.
- Reset mid-transfer: mem_valid drops immediately and the access is abandoned. No done is produced.
- Normal access:
  - request seen in IDLE at cycle N;
  - mem_valid high from N+1;
  - mem_ready first sampled high at cycle M ≥ N+1;
  - done at M+1.
- Minimum request-to-done latency is 2 cycles, so a stall-free access occupies 3 core cycles.
- Fault: request seen at N; done and fault at N+1; mem_valid never asserts.
- load_data is valid starting in the done cycle.
- A new request is accepted no earlier than the cycle after done (back-to-back accesses are allowed).
- mem_ready high in the same cycle mem_valid first rises completes the transfer. No extra wait state is added.
- mem_ready high while in IDLE or DONE: no effect.

## Test plan
- LW, addr 0x100, mem_rdata 0xDEADBEEF, mem_ready high immediately:
  - mem_addr = 0x100, mem_wstrb = 0000;
  - done 2 cycles after the request is seen;
  - load_data = 0xDEADBEEF.
- LB then LBU at addr 0x103 with mem_rdata 0x80FF_1234:
  - LB gives load_data = 0xFFFFFF80;
  - LBU gives 0x00000080.
- SH at addr 0x202, wdata 0x0000ABCD, mem_ready delayed 3 cycles:
  - mem_wstrb = 1100, mem_wdata = 0xABCDABCD, mem_addr = 0x200;
  - bus outputs stable through the wait;
  - done on the cycle after ready.
- LW at 0x101 and SH at 0x203:
  - done and fault at N+1;
  - mem_valid stays 0;
  - load_data keeps its prior value.
- Illegal store funct3 = 100: same fault behaviour as the misaligned case, and no bus activity.
- rst_n pulsed low while in REQ:
  - all outputs return to reset values asynchronously;
  - no done pulse;
  - the next request completes normally.
